// File: rtl/imm_sequencer_pkg.sv
// Shared encodings for the immediate sequencer: decode modes and sequencer states.
package imm_sequencer_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT    = 2'b00,
    IMM_ZEXT    = 2'b01,
    IMM_UPPER   = 2'b10,
    IMM_LONG_HI = 2'b11
  } imm_mode_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_HAVE_HI = 1'b1
  } seq_state_e;

  function automatic logic [15:0] imm_zext(input logic [7:0] b);
    return {8'h00, b};
  endfunction

  function automatic logic [15:0] imm_upper(input logic [7:0] b);
    return {b, 8'h00};
  endfunction

endpackage

// File: rtl/imm_sequencer_sign_extender.sv
// Sign-extends an IN_W-bit field to OUT_W bits.
// Purely combinational, no handshake.
module sign_extender #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/imm_sequencer.sv
// Builds 16-bit ALU immediates from 8-bit decode beats (sext/zext/upper/two-beat long).
// Latency: one cycle from accept to registered out_imm; one result per cycle.
// Backpressure: in_ready drops while a result is held unconsumed or during flush.
module imm_sequencer
  import imm_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_imm,
  input  logic [1:0]  in_mode,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic        busy,
  output logic        err
);

  seq_state_e       state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_imm_q, out_imm_d;
  logic             err_q, err_d;

  logic [15:0]      sext_imm;
  imm_mode_e        mode;
  logic             accept;
  logic             deliver;

  sign_extender #(
    .IN_W  (8),
    .OUT_W (16)
  ) u_sext (
    .din  (in_imm),
    .dout (sext_imm)
  );

  assign mode      = imm_mode_e'(in_mode);
  assign in_ready  = (~out_valid_q | out_ready) & ~flush;
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign busy      = (state_q == S_HAVE_HI);
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~deliver;
    out_imm_d   = out_imm_q;
    err_d       = 1'b0;

    // Flush wins over everything except reset; a same-cycle delivery is voided.
    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (mode)
              IMM_SEXT: begin
                out_valid_d = 1'b1;
                out_imm_d   = sext_imm;
              end
              IMM_ZEXT: begin
                out_valid_d = 1'b1;
                out_imm_d   = imm_zext(in_imm);
              end
              IMM_UPPER: begin
                out_valid_d = 1'b1;
                out_imm_d   = imm_upper(in_imm);
              end
              default: begin
                hi_d    = in_imm;
                cnt_d   = '0;
                state_d = S_HAVE_HI;
              end
            endcase
          end
        end
        default: begin
          if (accept) begin
            state_d = S_IDLE;
            if (mode == IMM_SEXT || mode == IMM_ZEXT) begin
              out_valid_d = 1'b1;
              out_imm_d   = {hi_q, in_imm};
            end else begin
              err_d = 1'b1;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Exit happens before the counter can run past TIMEOUT-1.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hi_q        <= 8'h00;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      err_q       <= err_d;
    end
  end

endmodule
